interrupt_arbiter: RTL and testbench

INTERRUPT_ARBITER -- requirements
Module: interrupt_arbiter

---
 rtl/interrupt_arbiter.sv | 112 +++++++++++
 tb/tb_interrupt_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/interrupt_arbiter.sv
// Prioritised interrupt arbiter: per-source synchronizer and edge/level capture
// feeding a non-preemptive IDLE/REQUEST/SERVICE handshake with the core.

module irq_lane #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic edge_mode,
  input  logic clr,
  output logic pending
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   synced;
  logic                   rise;

  assign synced = sync_q[SYNC_STAGES-1];
  assign rise   = synced & ~hist_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      hist_q  <= 1'b0;
      pending <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], src};
      hist_q <= synced;
      // a fresh edge outranks an acceptance clear in the same cycle
      pending <= edge_mode ? (rise | (pending & ~clr)) : synced;
    end
  end
endmodule

module interrupt_arbiter #(
  parameter int NUM_SRC     = 4,
  parameter int SYNC_STAGES = 2,
  localparam int ID_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [NUM_SRC-1:0] edge_mode,
  input  logic [NUM_SRC-1:0] irq_enable,
  input  logic               irq_ack,
  input  logic               irq_done,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_SRC-1:0] irq_pending
);
  typedef enum logic [1:0] {IDLE, REQUEST, SERVICE} state_t;

  state_t             state, state_nxt;
  logic [ID_W-1:0]    id_q, win_id;
  logic [NUM_SRC-1:0] pend, cand, clr;
  logic               any, accept;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_lane
    irq_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
      .clk       (clk),
      .reset     (reset),
      .src       (irq_src[g]),
      .edge_mode (edge_mode[g]),
      .clr       (clr[g]),
      .pending   (pend[g])
    );
  end

  assign cand   = pend & irq_enable;
  assign any    = |cand;
  assign accept = (state == REQUEST) && irq_ack;

  // lowest index wins
  always_comb begin
    win_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (cand[i]) win_id = ID_W'(i);
  end

  always_comb begin
    clr = '0;
    if (accept) clr[id_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      id_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any) id_q <= win_id;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any) state_nxt = REQUEST;
      REQUEST: if (irq_ack) state_nxt = SERVICE;
               else if (!cand[id_q]) state_nxt = IDLE;
      SERVICE: if (irq_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    irq_req     = (state == REQUEST);
    irq_id      = id_q;
    irq_pending = pend;
  end
endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed bench for interrupt_arbiter: stimulus queues expected request ids,
// a monitor checks each new irq_req assertion against that queue.

module tb_interrupt_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq_src, edge_mode, irq_enable;
  logic       irq_ack, irq_done;
  logic       irq_req;
  logic [1:0] irq_id;
  logic [3:0] irq_pending;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  interrupt_arbiter #(.NUM_SRC(4), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .irq_src     (irq_src),
    .edge_mode   (edge_mode),
    .irq_enable  (irq_enable),
    .irq_ack     (irq_ack),
    .irq_done    (irq_done),
    .irq_req     (irq_req),
    .irq_id      (irq_id),
    .irq_pending (irq_pending)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // monitor: every rising irq_req must match the next queued id
  initial begin
    logic req_prev;
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1 && irq_req === 1'b1 && !req_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_req actual_id=%0d expected=none at %0t", irq_id, $time);
        end else begin
          chk("req_id", int'(irq_id), exp_q.pop_front());
        end
      end
      req_prev = (irq_req === 1'b1);
    end
  end

  initial begin
    reset = 1'b1; irq_src = '0; edge_mode = 4'b1111; irq_enable = 4'b1111;
    irq_ack = 1'b0; irq_done = 1'b0;
    tick(3);
    chk("rst_req", int'(irq_req), 0);
    chk("rst_id", int'(irq_id), 0);
    chk("rst_pending", int'(irq_pending), 0);
    reset = 1'b0;
    tick(2);

    // edge pulse on source 2: pending after edge 2, request after edge 3
    exp_q.push_back(2);
    irq_src[2] = 1'b1; tick(1);           // edge 0
    irq_src[2] = 1'b0; tick(1);           // edge 1
    chk("lat_req_e1", int'(irq_req), 0);
    tick(1);                              // edge 2
    chk("lat_pend_e2", int'(irq_pending), 4'b0100);
    chk("lat_req_e2", int'(irq_req), 0);
    tick(1);                              // edge 3
    chk("lat_req_e3", int'(irq_req), 1);
    chk("lat_id_e3", int'(irq_id), 2);
    irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
    chk("edge_ack_pend", int'(irq_pending), 0);
    chk("edge_svc_req", int'(irq_req), 0);
    chk("edge_svc_id", int'(irq_id), 2);
    irq_done = 1'b1; tick(1); irq_done = 1'b0;
    tick(3);
    chk("edge_no_rereq", int'(irq_req), 0);

    // priority: sources 1 and 3 together
    exp_q.push_back(1); exp_q.push_back(3);
    irq_src = 4'b1010; tick(1); irq_src = '0; tick(3);
    chk("prio_id", int'(irq_id), 1);
    irq_done = 1'b1; tick(1); irq_done = 1'b0;   // done ignored in REQUEST
    chk("prio_done_ign", int'(irq_req), 1);
    irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
    chk("prio_pend", int'(irq_pending), 4'b1000);
    irq_done = 1'b1; tick(1); irq_done = 1'b0;   // now IDLE
    chk("prio_idle_req", int'(irq_req), 0);
    tick(1);
    chk("prio_rereq", int'(irq_req), 1);
    chk("prio_rereq_id", int'(irq_id), 3);
    irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
    irq_done = 1'b1; tick(1); irq_done = 1'b0;
    tick(2);

    // level source 0 held high through ack and done
    edge_mode = 4'b1110;
    exp_q.push_back(0); exp_q.push_back(0);
    irq_src[0] = 1'b1; tick(4);
    chk("lvl_req", int'(irq_req), 1);
    irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
    chk("lvl_pend_kept", int'(irq_pending), 4'b0001);
    irq_done = 1'b1; tick(1); irq_done = 1'b0;
    tick(1);
    chk("lvl_rereq", int'(irq_req), 1);
    chk("lvl_rereq_id", int'(irq_id), 0);
    irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
    irq_src[0] = 1'b0; tick(4);
    chk("lvl_pend_drop", int'(irq_pending), 0);
    irq_done = 1'b1; tick(1); irq_done = 1'b0;
    tick(3);
    chk("lvl_no_req", int'(irq_req), 0);
    edge_mode = 4'b1111;

    // withdraw: mask source 2 while requesting
    exp_q.push_back(2);
    irq_src[2] = 1'b1; tick(1); irq_src[2] = 1'b0; tick(3);
    chk("wd_req", int'(irq_req), 1);
    irq_enable[2] = 1'b0; tick(1);
    chk("wd_req_drop", int'(irq_req), 0);
    chk("wd_pend", int'(irq_pending), 4'b0100);
    tick(2);
    chk("wd_stays_idle", int'(irq_req), 0);
    exp_q.push_back(2);
    irq_enable[2] = 1'b1; tick(1);
    chk("wd_rereq", int'(irq_req), 1);
    irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
    irq_done = 1'b1; tick(1); irq_done = 1'b0;
    tick(2);

    // collision: new edge on source 1 lands with its ack
    exp_q.push_back(1); exp_q.push_back(1);
    irq_src[1] = 1'b1; tick(1); irq_src[1] = 1'b0; tick(3);
    chk("col_req", int'(irq_req), 1);
    irq_src[1] = 1'b1; tick(1); irq_src[1] = 1'b0; tick(1);
    irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
    chk("col_pend_kept", int'(irq_pending), 4'b0010);
    chk("col_svc", int'(irq_req), 0);
    irq_done = 1'b1; tick(1); irq_done = 1'b0;
    tick(1);
    chk("col_rereq", int'(irq_req), 1);
    irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
    chk("col_pend_clr", int'(irq_pending), 0);
    irq_done = 1'b1; tick(1); irq_done = 1'b0;
    tick(2);

    // reset mid-SERVICE, with source 2 held high through reset
    exp_q.push_back(3);
    irq_src[3] = 1'b1; tick(1); irq_src[3] = 1'b0; tick(3);
    irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
    irq_src[2] = 1'b1; tick(1);
    reset = 1'b1; tick(1);
    chk("mrst_req", int'(irq_req), 0);
    chk("mrst_id", int'(irq_id), 0);
    chk("mrst_pend", int'(irq_pending), 0);
    exp_q.push_back(2);
    reset = 1'b0; tick(2);
    chk("mrst_pend_e1", int'(irq_pending), 0);
    tick(2);
    chk("mrst_held_req", int'(irq_req), 1);
    chk("mrst_held_id", int'(irq_id), 2);
    irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
    irq_src[2] = 1'b0;
    irq_done = 1'b1; tick(1); irq_done = 1'b0;
    tick(6);
    chk("mrst_no_req", int'(irq_req), 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
